// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES key-schedule widths, rotation table, PC-1/PC-2 and 28-bit rotate helpers
package des_pkg;

  localparam int KEY_W  = 64;
  localparam int CD_W   = 56;
  localparam int HALF_W = 28;
  localparam int RK_W   = 48;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Per-round left-rotation amounts, indexed by round number minus 1.
  localparam logic [1:0] SHIFT [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Tables use the FIPS numbering: bit 1 is the MSB of the input word.
  localparam int PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [RK_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < CD_W; i++) begin
      r[CD_W-1-i] = key[KEY_W-PC1_TBL[i]];
    end
    return r;
  endfunction

  function automatic logic [RK_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [RK_W-1:0] r;
    r = '0;
    for (int i = 0; i < RK_W; i++) begin
      r[RK_W-1-i] = cd[CD_W-PC2_TBL[i]];
    end
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
    logic [HALF_W-1:0] r;
    case (n)
      2'd1:    r = {x[HALF_W-2:0], x[HALF_W-1]};
      2'd2:    r = {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
    logic [HALF_W-1:0] r;
    case (n)
      2'd1:    r = {x[0], x[HALF_W-1:1]};
      2'd2:    r = {x[1:0], x[HALF_W-1:2]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// rtl/des_pc2.sv - combinational PC-2 selection, 56-bit C/D state to 48-bit round key
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0] cd,
  output logic [RK_W-1:0] rk
);

  assign rk = pc2(cd);

endmodule

// File: rtl/key_sched_stream.sv
// rtl/key_sched_stream.sv - sequential DES key schedule, one round key per handshake
module key_sched_stream
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                decrypt,
  input  logic [KEY_W-1:0]    init_key,
  input  logic                key_ready,
  output logic                key_valid,
  output logic [RK_W-1:0]     round_key,
  output logic [3:0]          round_idx,
  output logic                busy,
  output logic                done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  state_t          state_q, state_d;
  logic            mode_q, mode_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic [3:0]      idx_q, idx_d;
  logic            done_q, done_d;

  logic [CD_W-1:0]   cd_init;
  logic [HALF_W-1:0] c_cur, d_cur;
  logic [3:0]        idx_inc, idx_dec;
  logic              last_xfer;

  assign cd_init = pc1(init_key);
  assign c_cur   = cd_q[CD_W-1:HALF_W];
  assign d_cur   = cd_q[HALF_W-1:0];
  assign idx_inc = idx_q + 4'd1;
  assign idx_dec = idx_q - 4'd1;
  assign last_xfer = mode_q ? (idx_q == 4'd0) : (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cd_d    = cd_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = decrypt;
          // C16/D16 equals C0/D0, so decrypt starts straight from PC-1.
          if (decrypt) begin
            cd_d  = cd_init;
            idx_d = LAST_IDX;
          end else begin
            cd_d  = {rotl28(cd_init[CD_W-1:HALF_W], SHIFT[0]),
                     rotl28(cd_init[HALF_W-1:0], SHIFT[0])};
            idx_d = 4'd0;
          end
        end
      end
      RUN: begin
        if (key_ready) begin
          if (last_xfer) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (mode_q) begin
            cd_d  = {rotr28(c_cur, SHIFT[idx_q]), rotr28(d_cur, SHIFT[idx_q])};
            idx_d = idx_dec;
          end else begin
            cd_d  = {rotl28(c_cur, SHIFT[idx_inc]), rotl28(d_cur, SHIFT[idx_inc])};
            idx_d = idx_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      cd_q    <= '0;
      idx_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cd_q    <= cd_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  des_pc2 u_pc2 (
    .cd (cd_q),
    .rk (round_key)
  );

  assign key_valid = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign round_idx = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_sched_stream.sv
// tb/tb_key_sched_stream.sv - scoreboard bench for key_sched_stream with directed key vectors
module tb_key_sched_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic [63:0] init_key = '0;
  logic        key_ready = 1'b1;
  logic        key_valid;
  logic [47:0] round_key;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic done_prev = 1'b0;

  typedef struct packed {
    logic [47:0] key;
    logic [3:0]  idx;
  } exp_t;

  exp_t exp_q [$];

  // Textbook round keys K1..K16 for key 133457799BBCDFF1.
  logic [47:0] ktab [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  key_sched_stream #(.NUM_ROUNDS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .decrypt   (decrypt),
    .init_key  (init_key),
    .key_ready (key_ready),
    .key_valid (key_valid),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] exp_key(input int sel, input int i);
    logic [47:0] k;
    case (sel)
      0:       k = 48'h0;
      1:       k = ktab[i];
      default: k = 48'hFFFFFFFFFFFF;
    endcase
    return k;
  endfunction

  // Monitor: pops one expected key per accepted transfer.
  always @(negedge clk) begin
    if (key_valid === 1'b1 && key_ready === 1'b1) begin
      xfers++;
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", {44'h0, round_idx, 16'h0}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("round_key_idx", {12'h0, round_key, round_idx}, {12'h0, e.key, e.idx});
      end
    end
    if (done === 1'b1) chk("done_single_pulse", {63'h0, done_prev}, 64'h0);
    done_prev <= (done === 1'b1);
  end

  // mode: 0 plain, 1 backpressure at idx 12, 2 ignored start at idx 8, 3 reset at idx 7
  task automatic run_sched(input logic [63:0] key, input logic dec, input int sel, input int mode);
    int  cyc;
    int  x0;
    int  stall;
    bit  acted;
    bit  got_done;
    cyc = 0; stall = 0; acted = 0; got_done = 0;
    for (int i = 0; i < 16; i++) begin
      int r;
      r = dec ? 15 - i : i;
      exp_q.push_back('{key: exp_key(sel, r), idx: 4'(r)});
    end
    x0 = xfers;
    init_key = key;
    decrypt  = dec;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    decrypt  = ~dec;
    while (cyc < 60 && !got_done) begin
      if (mode == 1 && !acted && key_valid && round_idx == 4'd12) begin
        key_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1; cyc++; stall++;
          chk("stall_idx_held", {60'h0, round_idx}, 64'd12);
          chk("stall_key_held", {16'h0, round_key}, {16'h0, ktab[12]});
        end
        key_ready = 1'b1;
        acted = 1;
      end else if (mode == 2 && !acted && key_valid && round_idx == 4'd8) begin
        start = 1'b1;
        init_key = 64'h0123456789ABCDEF;
        decrypt = ~dec;
        @(posedge clk); #1; cyc++;
        start = 1'b0;
        acted = 1;
      end else if (mode == 3 && key_valid && round_idx == 4'd7) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_key_valid", {63'h0, key_valid}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_round_key", {16'h0, round_key}, 64'h0);
        chk("rst_round_idx", {60'h0, round_idx}, 64'h0);
        exp_q.delete();
        repeat (4) begin
          chk("rst_no_done", {63'h0, done}, 64'h0);
          @(posedge clk); #1;
        end
        return;
      end
      @(posedge clk); #1; cyc++;
      if (done === 1'b1) got_done = 1;
    end
    if (!got_done) begin
      chk("done_timeout", 64'h0, 64'h1);
    end else begin
      chk("done_cycle", 64'(cyc), 64'(16 + stall));
      chk("busy_after_done", {63'h0, busy}, 64'h0);
      chk("valid_after_done", {63'h0, key_valid}, 64'h0);
      chk("all_keys_seen", 64'(exp_q.size()), 64'h0);
      chk("xfer_count", 64'(xfers - x0), 64'd16);
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_key_valid", {63'h0, key_valid}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    chk("reset_round_key", {16'h0, round_key}, 64'h0);
    chk("reset_round_idx", {60'h0, round_idx}, 64'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_sched(64'h0, 1'b1, 0, 0);
    run_sched(64'h133457799BBCDFF1, 1'b1, 1, 0);
    run_sched(64'h133457799BBCDFF1, 1'b0, 1, 0);
    run_sched(64'hFFFFFFFFFFFFFFFF, 1'b0, 2, 0);
    run_sched(64'hFFFFFFFFFFFFFFFF, 1'b1, 2, 0);
    run_sched(64'h133457799BBCDFF1, 1'b1, 1, 1);
    run_sched(64'h133457799BBCDFF1, 1'b0, 1, 2);
    run_sched(64'h133457799BBCDFF1, 1'b1, 1, 3);
    run_sched(64'h133457799BBCDFF1, 1'b1, 1, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
